// File: rtl/cla_pkg.sv
// Shared constants and elaboration-time helpers for the carry-lookahead adder.
//
// Contents:
//   CLA_GROUP_W      width of one first-level lookahead group (4 bits)
//   cla_ceil_div     integer ceiling division
//   cla_group_count  number of 4-bit groups needed for a given operand width
//   cla_clog2        ceiling log2, for sizing group indices
package cla_pkg;

  localparam int CLA_GROUP_W = 4;

  function automatic int cla_ceil_div(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

  function automatic int cla_group_count(input int width);
    return cla_ceil_div(width, CLA_GROUP_W);
  endfunction

  function automatic int cla_clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/cla_group4.sv
// First-level 4-bit carry-lookahead group (purely combinational).
//
// Produces the 4-bit sum for its slice given the group carry-in, plus the
// group propagate/generate pair consumed by the second-level lookahead unit.
// Every internal carry is written in flattened sum-of-products form, so no
// carry ripples from bit to bit inside the group.
//
// Ports:
//   a      in   [3:0]  operand A slice
//   b      in   [3:0]  operand B slice
//   c_in   in   1      carry into bit 0 of this group
//   sum    out  [3:0]  sum slice
//   grp_p  out  1      group propagate: all four bits propagate
//   grp_g  out  1      group generate: the group produces a carry by itself
module cla_group4
  import cla_pkg::*;
(
  input  logic [CLA_GROUP_W-1:0] a,
  input  logic [CLA_GROUP_W-1:0] b,
  input  logic                   c_in,
  output logic [CLA_GROUP_W-1:0] sum,
  output logic                   grp_p,
  output logic                   grp_g
);

  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] c;

  assign p = a ^ b;
  assign g = a & b;

  // Carry into each bit, expanded so each depends only on p, g and c_in.
  assign c[0] = c_in;
  assign c[1] = g[0]
              | (p[0] & c_in);
  assign c[2] = g[1]
              | (p[1] & g[0])
              | (p[1] & p[0] & c_in);
  assign c[3] = g[2]
              | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c_in);

  assign sum = p ^ c;

  // Group terms are independent of c_in; that is what lets the second
  // level compute every group carry in parallel.
  assign grp_p = &p;
  assign grp_g = g[3]
               | (p[3] & g[2])
               | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/carry_lookahead_adder.sv
// Registered WIDTH-bit two-level carry-lookahead adder.
//
// {cout, s} = a + b + cin, registered with one cycle of latency and a new
// operand set accepted every cycle. The operands are split into 4-bit
// groups (cla_group4); a second-level lookahead unit derives every group
// carry-in directly from the group propagate/generate terms and cin, so no
// carry ripples between groups. The only state is the WIDTH+1 output flops.
//
// WIDTH must be a multiple of 4 in the range 4..32.
//
// Ports:
//   clk   in   1      rising-edge clock
//   rst   in   1      synchronous active-high reset; clears s and cout
//   a     in   WIDTH  operand A, unsigned
//   b     in   WIDTH  operand B, unsigned
//   cin   in   1      carry-in
//   s     out  WIDTH  registered sum, low WIDTH bits of a+b+cin
//   cout  out  1      registered carry-out, bit WIDTH of a+b+cin
module carry_lookahead_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  localparam int NG = cla_group_count(WIDTH);

  logic [NG-1:0]    grp_p;
  logic [NG-1:0]    grp_g;
  logic [NG:1]      grp_carry;  // carry out of group j-1, i.e. into group j
  logic [NG-1:0]    grp_cin;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic [WIDTH-1:0] s_q;
  logic             cout_q;

  // First level: one lookahead group per 4-bit slice.
  for (genvar gi = 0; gi < NG; gi++) begin : g_grp
    if (gi == 0) begin : g_first
      assign grp_cin[gi] = cin;
    end else begin : g_rest
      assign grp_cin[gi] = grp_carry[gi];
    end

    cla_group4 u_grp (
      .a     (a[gi*CLA_GROUP_W +: CLA_GROUP_W]),
      .b     (b[gi*CLA_GROUP_W +: CLA_GROUP_W]),
      .c_in  (grp_cin[gi]),
      .sum   (sum_d[gi*CLA_GROUP_W +: CLA_GROUP_W]),
      .grp_p (grp_p[gi]),
      .grp_g (grp_g[gi])
    );
  end

  // Second level: C[j+1] in flattened lookahead form,
  //   C[j+1] = GG[j] | GP[j]GG[j-1] | ... | GP[j..1]GG[0] | GP[j..0]cin
  // Each product term is built from group signals only, never from another
  // group carry, so all group carries settle in parallel.
  logic carry_acc;
  logic carry_term;

  always_comb begin
    grp_carry  = '0;
    carry_acc  = 1'b0;
    carry_term = 1'b0;
    for (int j = 0; j < NG; j++) begin
      carry_acc = 1'b0;
      for (int k = 0; k <= j; k++) begin
        carry_term = grp_g[k];
        for (int m = k + 1; m <= j; m++) begin
          carry_term = carry_term & grp_p[m];
        end
        carry_acc = carry_acc | carry_term;
      end
      carry_term = cin;
      for (int m = 0; m <= j; m++) begin
        carry_term = carry_term & grp_p[m];
      end
      carry_acc        = carry_acc | carry_term;
      grp_carry[j + 1] = carry_acc;
    end
  end

  assign cout_d = grp_carry[NG];

  // Output register; reset wins over the operands presented that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q    <= '0;
      cout_q <= 1'b0;
    end else begin
      s_q    <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign s    = s_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_carry_lookahead_adder.sv
module tb_carry_lookahead_adder;

  localparam int W  = 4;
  localparam int WW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [W-1:0]  a4, b4, s4;
  logic          cin4, cout4;
  logic [WW-1:0] a16, b16, s16;
  logic          cin16, cout16;

  int checks = 0;
  int errors = 0;

  logic [W:0]  exp_q[$];
  logic [WW:0] exp16_q[$];

  carry_lookahead_adder #(.WIDTH(W)) dut4 (
    .clk (clk), .rst (rst), .a (a4), .b (b4), .cin (cin4),
    .s (s4), .cout (cout4)
  );

  carry_lookahead_adder #(.WIDTH(WW)) dut16 (
    .clk (clk), .rst (rst), .a (a16), .b (b16), .cin (cin16),
    .s (s16), .cout (cout16)
  );

  // Reference model: plain unsigned addition at WIDTH+1 bits.
  function automatic logic [W:0] ref4(input logic [W-1:0] x, input logic [W-1:0] y,
                                      input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  function automatic logic [WW:0] ref16(input logic [WW-1:0] x, input logic [WW-1:0] y,
                                        input logic c);
    return {1'b0, x} + {1'b0, y} + {{WW{1'b0}}, c};
  endfunction

  task automatic test_reset();
    rst = 1'b1; a4 = 4'hB; b4 = 4'h6; cin4 = 1'b0;
    a16 = 16'hFFFF; b16 = 16'h0001; cin16 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if ({cout4, s4} !== 5'd0) begin
      errors++;
      $display("FAIL reset_w4: got %0h expected 0", {cout4, s4});
    end
    checks++;
    if ({cout16, s16} !== 17'd0) begin
      errors++;
      $display("FAIL reset_w16: got %0h expected 0", {cout16, s16});
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta[6] = '{4'h1, 4'h2, 4'hB, 4'h5, 4'hF, 4'hF};
    logic [W-1:0] tb[6] = '{4'h0, 4'h4, 4'h6, 4'h3, 4'h0, 4'hF};
    logic         tc[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [W:0]   exp;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      a4 = ta[i]; b4 = tb[i]; cin4 = tc[i];
      exp = ref4(ta[i], tb[i], tc[i]);
      @(posedge clk); #1;
      checks++;
      if ({cout4, s4} !== exp) begin
        errors++;
        $display("FAIL directed[%0d] a=%0h b=%0h cin=%0b: got %0h expected %0h",
                 i, ta[i], tb[i], tc[i], {cout4, s4}, exp);
      end
    end
  endtask

  task automatic test_reset_mid_stream();
    logic [W:0] got;
    // Put a non-zero result in flight, then reset over new operands.
    rst = 1'b0; a4 = 4'h5; b4 = 4'h3; cin4 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({cout4, s4} !== 5'd9) begin
      errors++;
      $display("FAIL midreset_load: got %0d expected 9", {cout4, s4});
    end
    rst = 1'b1; a4 = 4'hB; b4 = 4'h6; cin4 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({cout4, s4} !== 5'd0) begin
      errors++;
      $display("FAIL midreset_clear: got %0d expected 0", {cout4, s4});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    got = {cout4, s4};
    checks++;
    if (got !== 5'd17) begin
      errors++;
      $display("FAIL midreset_release: got %0d expected 17", got);
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] v;
    logic [W:0] exp;
    rst = 1'b0;
    for (int i = 0; i < 512; i++) begin
      v = i[8:0];
      a4 = v[3:0]; b4 = v[7:4]; cin4 = v[8];
      exp_q.push_back(ref4(v[3:0], v[7:4], v[8]));
      @(posedge clk); #1;
      exp = exp_q.pop_front();
      checks++;
      if ({cout4, s4} !== exp) begin
        errors++;
        $display("FAIL sweep[%0d]: got %0h expected %0h", i, {cout4, s4}, exp);
      end
    end
  endtask

  task automatic test_wide_random();
    logic [WW:0]   exp;
    logic [WW-1:0] x, y;
    logic          c;
    int            grp;
    rst = 1'b0;
    for (int i = 0; i < 400; i++) begin
      x = 16'($urandom_range(0, 65535));
      c = 1'($urandom_range(0, 1));
      if (i == 0) begin
        x = 16'hFFFF; y = 16'hFFFF; c = 1'b1;
      end else if (i == 1) begin
        x = 16'hFFFF; y = 16'h0000; c = 1'b1;
      end else if (i[0]) begin
        y = 16'($urandom_range(0, 65535));
      end else begin
        // Every group propagates except one random group, which stresses
        // long group-to-group carry paths.
        y = ~x;
        grp = $urandom_range(0, 3);
        x[grp*4 +: 4] = 4'($urandom_range(0, 15));
        y[grp*4 +: 4] = 4'($urandom_range(0, 15));
      end
      a16 = x; b16 = y; cin16 = c;
      exp16_q.push_back(ref16(x, y, c));
      @(posedge clk); #1;
      exp = exp16_q.pop_front();
      checks++;
      if ({cout16, s16} !== exp) begin
        errors++;
        $display("FAIL wide[%0d] a=%0h b=%0h cin=%0b: got %0h expected %0h",
                 i, x, y, c, {cout16, s16}, exp);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    a4 = '0; b4 = '0; cin4 = 1'b0;
    a16 = '0; b16 = '0; cin16 = 1'b0;
    test_reset();
    test_directed();
    test_reset_mid_stream();
    test_back_to_back();
    test_wide_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
